// File: rtl/alu_md_pkg.sv
// alu_md_pkg: shared encodings for the execute-stage ALU / mul-div control.
// Holds the 4-bit ALU control codes, the ALUOp and funct7 encodings, the
// RV-M funct3 encodings, the control FSM state type and a small helper that
// maps a base-ISA funct3 onto its ALU code.
package alu_md_pkg;

    // ALU control codes driven on o_ALUControlLines
    localparam logic [3:0] ALUC_AND  = 4'b0000;
    localparam logic [3:0] ALUC_OR   = 4'b0001;
    localparam logic [3:0] ALUC_ADD  = 4'b0010;
    localparam logic [3:0] ALUC_SUB  = 4'b0110;
    localparam logic [3:0] ALUC_SLT  = 4'b0111;
    localparam logic [3:0] ALUC_SLTU = 4'b1000;
    localparam logic [3:0] ALUC_XOR  = 4'b1001;
    localparam logic [3:0] ALUC_SLL  = 4'b1010;
    localparam logic [3:0] ALUC_SRL  = 4'b1011;
    localparam logic [3:0] ALUC_SRA  = 4'b1100;
    localparam logic [3:0] ALUC_MD   = 4'b1111;

    // ALUOp encodings coming from the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    // funct7 values that select a family of R-type operations
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // RV-M funct3 encodings; bit 2 separates divide from multiply
    localparam logic [2:0] MF3_MUL    = 3'b000;
    localparam logic [2:0] MF3_MULH   = 3'b001;
    localparam logic [2:0] MF3_MULHSU = 3'b010;
    localparam logic [2:0] MF3_MULHU  = 3'b011;
    localparam logic [2:0] MF3_DIV    = 3'b100;
    localparam logic [2:0] MF3_DIVU   = 3'b101;
    localparam logic [2:0] MF3_REM    = 3'b110;
    localparam logic [2:0] MF3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ALU_OUT = 2'b01,
        ST_MD_RUN  = 2'b10,
        ST_MD_DONE = 2'b11
    } state_e;

    // Base-ISA funct3 to ALU code (funct3 101 maps to the logical shift)
    function automatic logic [3:0] baseCode(input logic [2:0] funct3);
        case (funct3)
            3'b000:  baseCode = ALUC_ADD;
            3'b001:  baseCode = ALUC_SLL;
            3'b010:  baseCode = ALUC_SLT;
            3'b011:  baseCode = ALUC_SLTU;
            3'b100:  baseCode = ALUC_XOR;
            3'b101:  baseCode = ALUC_SRL;
            3'b110:  baseCode = ALUC_OR;
            default: baseCode = ALUC_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_md_control_md_iter.sv
// md_iter: iterative RV-M datapath, one radix-2 step per clock.
// Ports: clk_i/rst_i (async, active-high), start_i loads operands, abort_i
// drops an in-flight op, op_i is the M funct3, a_i/b_i operands, done_o is
// high during the final step edge and result_o is the sign-corrected result
// valid while done_o is high.
module md_iter
    import alu_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);

    logic              busy_q;
    logic [CW-1:0]     count_q;
    logic [2:0]        op_q;
    logic              negRes_q;
    logic [XLEN-1:0]   opB_q;
    logic [2*XLEN-1:0] prod_q, prod_d;

    logic              signA, signB, negStart;
    logic [XLEN-1:0]   magA, magB;
    logic [XLEN:0]     mulSum, divTrial;
    logic [2*XLEN-1:0] prodNeg;

    // Operand signedness follows the RISC-V rules; unsigned operands just
    // report a clear sign bit, so one negate-on-sign path serves every op.
    always_comb begin
        signA = a_i[XLEN-1] & (op_i != MF3_MULHU) & (op_i != MF3_DIVU) & (op_i != MF3_REMU);
        signB = b_i[XLEN-1] & ((op_i == MF3_MUL) | (op_i == MF3_MULH) |
                               (op_i == MF3_DIV) | (op_i == MF3_REM));
        magA = signA ? -a_i : a_i;
        magB = signB ? -b_i : b_i;
        // Remainder takes the dividend's sign; everything else is sign XOR
        negStart = (op_i[2] & op_i[1]) ? signA : (signA ^ signB);
    end

    // One iteration. Multiply: conditional add of the multiplicand into the
    // upper half, then shift right. Divide: restoring step on {rem, quot};
    // the trial includes the bit shifted out of the top so a remainder close
    // to 2^XLEN is never truncated.
    always_comb begin
        prod_d   = prod_q;
        mulSum   = '0;
        divTrial = '0;
        if (op_q[2]) begin
            divTrial = prod_q[2*XLEN-1:XLEN-1] - {1'b0, opB_q};
            if (!divTrial[XLEN]) begin
                prod_d = {divTrial[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
            end else begin
                prod_d = {prod_q[2*XLEN-2:0], 1'b0};
            end
        end else begin
            mulSum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opB_q} : '0);
            prod_d = {mulSum, prod_q[XLEN-1:1]};
        end
    end

    // Sign fix applied to the post-final-step value
    always_comb begin
        prodNeg = -prod_d;
        case (op_q)
            MF3_MUL:            result_o = negRes_q ? prodNeg[XLEN-1:0] : prod_d[XLEN-1:0];
            MF3_MULH, MF3_MULHSU,
            MF3_MULHU:          result_o = negRes_q ? prodNeg[2*XLEN-1:XLEN] : prod_d[2*XLEN-1:XLEN];
            MF3_DIV, MF3_DIVU:  result_o = negRes_q ? -prod_d[XLEN-1:0] : prod_d[XLEN-1:0];
            default:            result_o = negRes_q ? -prod_d[2*XLEN-1:XLEN] : prod_d[2*XLEN-1:XLEN];
        endcase
    end

    assign done_o = busy_q && (count_q == '0);

    // Operand load on start; XLEN steps counted down from XLEN-1 to 0
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q   <= 1'b0;
            count_q  <= '0;
            op_q     <= MF3_MUL;
            negRes_q <= 1'b0;
            opB_q    <= '0;
            prod_q   <= '0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            count_q  <= CW'(XLEN - 1);
            op_q     <= op_i;
            negRes_q <= negStart;
            opB_q    <= magB;
            prod_q   <= {{XLEN{1'b0}}, magA};
        end else if (busy_q) begin
            prod_q <= prod_d;
            if (count_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_md_control.sv
// alu_md_control: execute-stage ALU-op decode, single-cycle ALU and RV-M
// sequencing behind a valid/ready handshake.
// Ports: i_clk/i_rst (async, active-high), i_valid/o_ready accept handshake,
// i_flush aborts, i_ALUOp/i_Funct3/i_Funct7 select the op, i_A/i_B operands;
// o_valid pulses with o_Result, o_ALUControlLines (last accepted code) and
// o_illegal (undecodable op).
module alu_md_control
    import alu_md_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_flush,
    input  logic [1:0]      i_ALUOp,
    input  logic [2:0]      i_Funct3,
    input  logic [6:0]      i_Funct7,
    input  logic [XLEN-1:0] i_A,
    input  logic [XLEN-1:0] i_B,
    output logic            o_valid,
    output logic [XLEN-1:0] o_Result,
    output logic [3:0]      o_ALUControlLines,
    output logic            o_illegal
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q;
    logic            valid_q, illegal_q;
    logic [XLEN-1:0] result_q;
    logic [3:0]      aluCode_q;

    logic [3:0]      decCode;
    logic            decIsM, decIllegal;
    logic [XLEN-1:0] aluResult, mFastResult, mdResult;
    logic            mFast, mdDone, accept, mdStart;
    logic [SHW-1:0]  shamt;

    // Decode ALUOp/funct fields into an ALU code, an M-op flag or illegal
    always_comb begin
        decCode    = ALUC_ADD;
        decIsM     = 1'b0;
        decIllegal = 1'b0;
        case (i_ALUOp)
            ALUOP_ADD: decCode = ALUC_ADD;
            ALUOP_SUB: decCode = ALUC_SUB;
            ALUOP_RTYPE: begin
                if (i_Funct7 == F7_BASE) begin
                    decCode = baseCode(i_Funct3);
                end else if (i_Funct7 == F7_ALT && i_Funct3 == 3'b000) begin
                    decCode = ALUC_SUB;
                end else if (i_Funct7 == F7_ALT && i_Funct3 == 3'b101) begin
                    decCode = ALUC_SRA;
                end else if (i_Funct7 == F7_MULDIV && EN_M) begin
                    decCode = ALUC_MD;
                    decIsM  = 1'b1;
                end else begin
                    decIllegal = 1'b1;
                end
            end
            default: begin
                // I-type: funct7 is immediate bits except for the shifts
                decCode = baseCode(i_Funct3);
                if (i_Funct3 == 3'b001 && i_Funct7 != F7_BASE) begin
                    decIllegal = 1'b1;
                end else if (i_Funct3 == 3'b101) begin
                    if (i_Funct7 == F7_ALT) begin
                        decCode = ALUC_SRA;
                    end else if (i_Funct7 != F7_BASE) begin
                        decIllegal = 1'b1;
                    end
                end
            end
        endcase
    end

    assign shamt = i_B[SHW-1:0];

    // Single-cycle ALU evaluated on the decoded code
    always_comb begin
        case (decCode)
            ALUC_AND:  aluResult = i_A & i_B;
            ALUC_OR:   aluResult = i_A | i_B;
            ALUC_ADD:  aluResult = i_A + i_B;
            ALUC_SUB:  aluResult = i_A - i_B;
            ALUC_SLT:  aluResult = {{(XLEN-1){1'b0}}, $signed(i_A) < $signed(i_B)};
            ALUC_SLTU: aluResult = {{(XLEN-1){1'b0}}, i_A < i_B};
            ALUC_XOR:  aluResult = i_A ^ i_B;
            ALUC_SLL:  aluResult = i_A << shamt;
            ALUC_SRL:  aluResult = i_A >> shamt;
            ALUC_SRA:  aluResult = $signed(i_A) >>> shamt;
            default:   aluResult = '0;
        endcase
    end

    // Divide-by-zero and signed overflow bypass the iterator entirely
    always_comb begin
        mFast       = 1'b0;
        mFastResult = '0;
        if (i_Funct3[2]) begin
            if (i_B == '0) begin
                mFast       = 1'b1;
                mFastResult = i_Funct3[1] ? i_A : '1;
            end else if (!i_Funct3[0] && i_A == INT_MIN && i_B == '1) begin
                mFast       = 1'b1;
                mFastResult = i_Funct3[1] ? '0 : i_A;
            end
        end
    end

    assign o_ready = (state_q != ST_MD_RUN);
    assign accept  = i_valid && o_ready && !i_flush;
    assign mdStart = accept && decIsM && !mFast;
    assign o_valid = valid_q && !i_flush;

    md_iter #(.XLEN(XLEN)) u_md_iter (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .start_i  (mdStart),
        .abort_i  (i_flush),
        .op_i     (i_Funct3),
        .a_i      (i_A),
        .b_i      (i_B),
        .done_o   (mdDone),
        .result_o (mdResult)
    );

    // Control FSM with registered result, code, valid and illegal outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            result_q  <= '0;
            aluCode_q <= ALUC_AND;
        end else if (i_flush) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
        end else if (state_q == ST_MD_RUN) begin
            valid_q <= 1'b0;
            if (mdDone) begin
                state_q   <= ST_MD_DONE;
                valid_q   <= 1'b1;
                illegal_q <= 1'b0;
                result_q  <= mdResult;
            end
        end else if (accept) begin
            if (mdStart) begin
                state_q   <= ST_MD_RUN;
                valid_q   <= 1'b0;
                aluCode_q <= ALUC_MD;
            end else begin
                state_q   <= ST_ALU_OUT;
                valid_q   <= 1'b1;
                illegal_q <= decIllegal;
                aluCode_q <= decIllegal ? ALUC_AND : decCode;
                result_q  <= decIllegal ? '0 : (decIsM ? mFastResult : aluResult);
            end
        end else begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
        end
    end

    assign o_Result          = result_q;
    assign o_ALUControlLines = aluCode_q;
    assign o_illegal         = illegal_q;

endmodule

// File: tb/tb_alu_md_control.sv
// tb_alu_md_control: directed bench for alu_md_control at XLEN = 32, with a
// second instance built with EN_M = 0 sharing the same stimulus.
module tb_alu_md_control;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        i_flush;
    logic [1:0]  i_ALUOp;
    logic [2:0]  i_Funct3;
    logic [6:0]  i_Funct7;
    logic [31:0] i_A;
    logic [31:0] i_B;

    logic        o_ready, o_valid, o_illegal;
    logic [31:0] o_Result;
    logic [3:0]  o_ALUControlLines;

    logic        noM_ready, noM_valid, noM_illegal;
    logic [31:0] noM_Result;
    logic [3:0]  noM_ALUControlLines;

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        logic [1:0]  aluOp;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  code;
        logic        ill;
    } aluVec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } mdVec_t;

    aluVec_t aluVecs[15];
    mdVec_t  mdVecs[8];

    alu_md_control #(.XLEN(32), .EN_M(1'b1)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .i_flush           (i_flush),
        .i_ALUOp           (i_ALUOp),
        .i_Funct3          (i_Funct3),
        .i_Funct7          (i_Funct7),
        .i_A               (i_A),
        .i_B               (i_B),
        .o_valid           (o_valid),
        .o_Result          (o_Result),
        .o_ALUControlLines (o_ALUControlLines),
        .o_illegal         (o_illegal)
    );

    alu_md_control #(.XLEN(32), .EN_M(1'b0)) dutNoM (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_valid           (i_valid),
        .o_ready           (noM_ready),
        .i_flush           (i_flush),
        .i_ALUOp           (i_ALUOp),
        .i_Funct3          (i_Funct3),
        .i_Funct7          (i_Funct7),
        .i_A               (i_A),
        .i_B               (i_B),
        .o_valid           (noM_valid),
        .o_Result          (noM_Result),
        .o_ALUControlLines (noM_ALUControlLines),
        .o_illegal         (noM_illegal)
    );

    always #5 i_clk = ~i_clk;

    // Count every comparison and report any mismatch on one line
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one op for exactly one accept edge, return #1 after that edge
    task automatic applyStimulus(input logic [1:0] aluOp, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] a,
                                 input logic [31:0] b);
        i_valid  = 1'b1;
        i_ALUOp  = aluOp;
        i_Funct3 = f3;
        i_Funct7 = f7;
        i_A      = a;
        i_B      = b;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Called in cycle 1 after an M accept; bounded wait for the result pulse
    task automatic waitMdResult(input string tag, input logic [31:0] expRes);
        int cyc;
        bit readyLow;
        cyc      = 1;
        readyLow = 1'b1;
        while (!o_valid && cyc < 40) begin
            if (o_ready) readyLow = 1'b0;
            @(posedge i_clk);
            #1;
            cyc++;
        end
        checkOutput({tag, " latency"}, 64'(cyc), 64'd33);
        checkOutput({tag, " readyLow"}, 64'(readyLow), 64'd1);
        checkOutput({tag, " valid"}, 64'(o_valid), 64'd1);
        checkOutput({tag, " result"}, 64'(o_Result), 64'(expRes));
        checkOutput({tag, " code"}, 64'(o_ALUControlLines), 64'hF);
        checkOutput({tag, " readyDone"}, 64'(o_ready), 64'd1);
    endtask

    // Count o_valid pulses over a window where none are expected
    task automatic watchQuiet(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) pulses++;
        end
        checkOutput({tag, " no late valid"}, 64'(pulses), 64'd0);
    endtask

    initial begin
        aluVecs[0]  = '{2'b10, 3'b000, 7'd0,  32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFF4, 4'b0010, 1'b0};
        aluVecs[1]  = '{2'b10, 3'b001, 7'd0,  32'hFFFF_FFF0, 32'd4, 32'hFFFF_FF00, 4'b1010, 1'b0};
        aluVecs[2]  = '{2'b10, 3'b010, 7'd0,  32'hFFFF_FFF0, 32'd4, 32'h0000_0001, 4'b0111, 1'b0};
        aluVecs[3]  = '{2'b10, 3'b011, 7'd0,  32'hFFFF_FFF0, 32'd4, 32'h0000_0000, 4'b1000, 1'b0};
        aluVecs[4]  = '{2'b10, 3'b100, 7'd0,  32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFF4, 4'b1001, 1'b0};
        aluVecs[5]  = '{2'b10, 3'b101, 7'd0,  32'hFFFF_FFF0, 32'd4, 32'h0FFF_FFFF, 4'b1011, 1'b0};
        aluVecs[6]  = '{2'b10, 3'b110, 7'd0,  32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFF4, 4'b0001, 1'b0};
        aluVecs[7]  = '{2'b10, 3'b111, 7'd0,  32'hFFFF_FFF0, 32'd4, 32'h0000_0000, 4'b0000, 1'b0};
        aluVecs[8]  = '{2'b10, 3'b000, 7'd32, 32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFEC, 4'b0110, 1'b0};
        aluVecs[9]  = '{2'b10, 3'b101, 7'd32, 32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFFF, 4'b1100, 1'b0};
        aluVecs[10] = '{2'b10, 3'b001, 7'd32, 32'hFFFF_FFF0, 32'd4, 32'h0000_0000, 4'b0000, 1'b1};
        aluVecs[11] = '{2'b00, 3'b111, 7'd5,  32'd10,        32'd3, 32'd13,        4'b0010, 1'b0};
        aluVecs[12] = '{2'b01, 3'b000, 7'd0,  32'd10,        32'd3, 32'd7,         4'b0110, 1'b0};
        aluVecs[13] = '{2'b11, 3'b101, 7'd32, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 4'b1100, 1'b0};
        aluVecs[14] = '{2'b11, 3'b001, 7'd32, 32'd1,         32'd2, 32'h0000_0000, 4'b0000, 1'b1};

        mdVecs[0] = '{3'b001, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF};
        mdVecs[1] = '{3'b011, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001};
        mdVecs[2] = '{3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD};
        mdVecs[3] = '{3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF};
        mdVecs[4] = '{3'b000, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFA};
        mdVecs[5] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        mdVecs[6] = '{3'b101, 32'd100,       32'd7,        32'd14};
        mdVecs[7] = '{3'b111, 32'd100,       32'd7,        32'd2};

        i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
        i_ALUOp = 2'b00; i_Funct3 = 3'b000; i_Funct7 = 7'd0; i_A = '0; i_B = '0;

        $display("[TB] reset state");
        #12;
        checkOutput("reset valid", 64'(o_valid), 64'd0);
        checkOutput("reset result", 64'(o_Result), 64'd0);
        checkOutput("reset code", 64'(o_ALUControlLines), 64'd0);
        checkOutput("reset illegal", 64'(o_illegal), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        checkOutput("reset ready", 64'(o_ready), 64'd1);

        $display("[TB] back-to-back ALU sweep");
        i_valid = 1'b1;
        for (int k = 0; k < 15; k++) begin
            i_ALUOp  = aluVecs[k].aluOp;
            i_Funct3 = aluVecs[k].f3;
            i_Funct7 = aluVecs[k].f7;
            i_A      = aluVecs[k].a;
            i_B      = aluVecs[k].b;
            @(posedge i_clk);
            #1;
            checkOutput($sformatf("alu%0d valid", k), 64'(o_valid), 64'd1);
            checkOutput($sformatf("alu%0d result", k), 64'(o_Result), 64'(aluVecs[k].res));
            checkOutput($sformatf("alu%0d code", k), 64'(o_ALUControlLines), 64'(aluVecs[k].code));
            checkOutput($sformatf("alu%0d illegal", k), 64'(o_illegal), 64'(aluVecs[k].ill));
        end
        i_valid = 1'b0;
        @(posedge i_clk);
        #1;
        checkOutput("alu valid drops", 64'(o_valid), 64'd0);

        $display("[TB] M ops");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(2'b10, mdVecs[k].f3, 7'd1, mdVecs[k].a, mdVecs[k].b);
            waitMdResult($sformatf("md%0d", k), mdVecs[k].res);
        end

        $display("[TB] reset during MUL");
        applyStimulus(2'b10, 3'b000, 7'd1, 32'd7, 32'd6);
        repeat (9) begin
            @(posedge i_clk);
            #1;
        end
        i_rst = 1'b1;
        #1;
        checkOutput("midrst valid", 64'(o_valid), 64'd0);
        checkOutput("midrst result", 64'(o_Result), 64'd0);
        checkOutput("midrst code", 64'(o_ALUControlLines), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        checkOutput("midrst ready", 64'(o_ready), 64'd1);
        watchQuiet("midrst", 40);

        $display("[TB] divide fast paths");
        applyStimulus(2'b10, 3'b101, 7'd1, 32'd5, 32'd0);
        checkOutput("divu0 valid", 64'(o_valid), 64'd1);
        checkOutput("divu0 result", 64'(o_Result), 64'hFFFF_FFFF);
        checkOutput("divu0 code", 64'(o_ALUControlLines), 64'hF);
        applyStimulus(2'b10, 3'b110, 7'd1, 32'd5, 32'd0);
        checkOutput("rem0 valid", 64'(o_valid), 64'd1);
        checkOutput("rem0 result", 64'(o_Result), 64'd5);
        applyStimulus(2'b10, 3'b100, 7'd1, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("divovf valid", 64'(o_valid), 64'd1);
        checkOutput("divovf result", 64'(o_Result), 64'h8000_0000);
        checkOutput("divovf illegal", 64'(o_illegal), 64'd0);
        applyStimulus(2'b10, 3'b110, 7'd1, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("removf valid", 64'(o_valid), 64'd1);
        checkOutput("removf result", 64'(o_Result), 64'd0);

        $display("[TB] flush during DIV");
        applyStimulus(2'b10, 3'b100, 7'd1, 32'hFFFF_FFF9, 32'd2);
        repeat (4) begin
            @(posedge i_clk);
            #1;
        end
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_ALUOp = 2'b00; i_Funct3 = 3'b000; i_Funct7 = 7'd0; i_A = 32'd2; i_B = 32'd3;
        checkOutput("flush valid same", 64'(o_valid), 64'd0);
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        checkOutput("flush valid next", 64'(o_valid), 64'd0);
        checkOutput("flush ready", 64'(o_ready), 64'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        checkOutput("post-flush add valid", 64'(o_valid), 64'd1);
        checkOutput("post-flush add result", 64'(o_Result), 64'd5);
        watchQuiet("flush", 40);

        $display("[TB] EN_M = 0 instance");
        applyStimulus(2'b10, 3'b000, 7'd1, 32'd6, 32'd7);
        checkOutput("noM valid", 64'(noM_valid), 64'd1);
        checkOutput("noM illegal", 64'(noM_illegal), 64'd1);
        checkOutput("noM result", 64'(noM_Result), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
